// File: rtl/saph_fpu_issue_if.sv
// Bundle of requester, FPI and response signals for the FPU issue stage.
// The master side is the issue stage itself; the slave side is the surrounding environment.
interface saph_fpu_issue_if #(
    parameter int N      = 4,
    parameter int WIDTH  = 32,
    parameter int MODE_W = 4
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N*WIDTH-1:0]    req_lhs;
    logic [N*WIDTH-1:0]    req_rhs;
    logic [N*MODE_W-1:0]   req_mode;

    logic                  d_trig;
    logic [WIDTH-1:0]      d_lhs;
    logic [WIDTH-1:0]      d_rhs;
    logic [MODE_W-1:0]     d_mode;
    logic                  d_ready;
    logic [WIDTH-1:0]      q_res;
    logic [2**MODE_W-1:0]  has_modes;

    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [WIDTH-1:0]      resp_res;
    logic                  resp_err;
    logic                  busy;

    modport master (
        input  req_valid, req_lhs, req_rhs, req_mode, d_ready, q_res, has_modes,
        output req_ready, d_trig, d_lhs, d_rhs, d_mode,
        output resp_valid, resp_id, resp_res, resp_err, busy
    );

    modport slave (
        output req_valid, req_lhs, req_rhs, req_mode, d_ready, q_res, has_modes,
        input  req_ready, d_trig, d_lhs, d_rhs, d_mode,
        input  resp_valid, resp_id, resp_res, resp_err, busy
    );
endinterface

// File: rtl/saph_fpu_issue.sv
// Round-robin issue stage feeding one fixed-latency FPU; a tag pipeline follows each op
// so its result (or an unsupported-mode error) returns tagged with the requester index.
module saph_fpu_issue #(
    parameter int N       = 4,
    parameter int WIDTH   = 32,
    parameter int MODE_W  = 4,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    saph_fpu_issue_if.master bus
);
    localparam int ID_W = $clog2(N);

    if (LATENCY < 1) begin : g_bad_latency
        $error("saph_fpu_issue: LATENCY must be at least 1");
    end
    if (N < 2) begin : g_bad_n
        $error("saph_fpu_issue: N must be at least 2");
    end

    logic [ID_W-1:0]    ptr;
    logic [N-1:0]       eligible;
    logic               grant;
    logic [ID_W-1:0]    grant_idx;
    logic [MODE_W-1:0]  grant_mode;
    logic               legal;

    logic [LATENCY-1:0] tag_valid;
    logic [LATENCY-1:0] tag_err;
    logic [ID_W-1:0]    tag_id [LATENCY];

    // First eligible requester at or above ptr, wrapping; reset and FPU stall empty the set.
    always_comb begin
        eligible  = (bus.d_ready && !rst) ? bus.req_valid : '0;
        grant     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant && eligible[(int'(ptr) + k) % N]) begin
                grant     = 1'b1;
                grant_idx = ID_W'((int'(ptr) + k) % N);
            end
        end
    end

    always_comb begin
        grant_mode    = bus.req_mode[int'(grant_idx)*MODE_W +: MODE_W];
        legal         = bus.has_modes[grant_mode];
        bus.req_ready = '0;
        bus.d_trig    = 1'b0;
        bus.d_lhs     = '0;
        bus.d_rhs     = '0;
        bus.d_mode    = '0;
        if (grant) begin
            bus.req_ready[grant_idx] = 1'b1;
            bus.d_trig               = legal;
            bus.d_lhs                = bus.req_lhs[int'(grant_idx)*WIDTH +: WIDTH];
            bus.d_rhs                = bus.req_rhs[int'(grant_idx)*WIDTH +: WIDTH];
            bus.d_mode               = grant_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Only the valid bits need clearing; id/err are don't-care while their valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
        end else begin
            tag_valid[0] <= grant;
            for (int s = 1; s < LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0]  <= grant_idx;
        tag_err[0] <= ~legal;
        for (int s = 1; s < LATENCY; s++) begin
            tag_id[s]  <= tag_id[s-1];
            tag_err[s] <= tag_err[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= '0;
            bus.resp_res   <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= tag_valid[LATENCY-1];
            bus.resp_id    <= tag_id[LATENCY-1];
            bus.resp_err   <= tag_err[LATENCY-1];
            bus.resp_res   <= tag_err[LATENCY-1] ? '0 : bus.q_res;
        end
    end

    assign bus.busy = !rst && ((|tag_valid) || bus.resp_valid);
endmodule
